aes_stream_arb: RTL
===================

Name: aes_stream_arb

Overview:
- Arbitrates two independent client streams onto the single 32-bit word stream that feeds the AES core (data_in_valid / data_in_type / data_in).
- Grants whole 4-word frames (one 128-bit block or key), never interleaving words of different frames, since the core's input packer has no frame delimiter or backpressure.
- Round-robin fairness; data frames are admitted only when the core reports crypto_ready, key frames are admitted unconditionally.
- Tracks which client last loaded the key.

Parameters:
FRAME_WORDS, 4, words per frame; fixed at 4 for the AES core, counter width 2 bits
TYPE_KEY, 2'b01, data_in_type encoding identifying a key frame; all other encodings are data frames

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, synchronous active-high (all state cleared on rising clk while rst=1)
req0_valid  in  1  client 0 word valid
req0_type  in  2  client 0 word type; sampled on first word of a frame
req0_data  in  32  client 0 word
req0_ready  out  1  client 0 word accepted this cycle
req1_valid  in  1  client 1 word valid
req1_type  in  2  client 1 word type
req1_data  in  32  client 1 word
req1_ready  out  1  client 1 word accepted this cycle
crypto_ready  in  1  core ready for a data block
data_in_valid  out  1  to core: word valid (registered)
data_in_type  out  2  to core: word type (registered)
data_in  out  32  to core: word (registered)
grant  out  2  one-hot current frame owner, 2'b00 when idle
key_owner  out  1  client index that loaded the current key
key_loaded  out  1  a key frame has completed since reset

Behaviour:
- Reset values: req*_ready=0, data_in_valid=0, data_in_type=0, data_in=0, grant=0, key_owner=0, key_loaded=0. Internal state: rr_ptr=0, FSM=IDLE, word_cnt=0.
- FSM states IDLE, BURST.
- IDLE:
  - Client i is eligible when req_i_valid=1 and (req_i_type==TYPE_KEY or crypto_ready=1).
  - One eligible client: grant it.
  - Both eligible: grant client rr_ptr.
  - None eligible: stay in IDLE.
  - Grant is registered: grant and FSM=BURST take effect the next cycle. No word is accepted in IDLE; req*_ready=0.
- BURST:
  - req_ready(owner) = 1; the other ready = 0.
  - A word is accepted when owner valid=1 (ready is always 1, because the core cannot stall).
  - Accepted word appears on data_in/data_in_type with data_in_valid=1 exactly one cycle later; data_in_valid=0 in cycles with no accept.
  - Frame type is latched from the first accepted word. Subsequent words are driven with the latched type, whatever the client presents.
  - word_cnt increments on each accept and wraps 3→0. The accept at word_cnt=3 ends the frame: FSM=IDLE, grant=0, rr_ptr = ~owner, all next cycle.
  - If the frame was a key frame: key_owner=owner and key_loaded=1, updated on the same edge.
  - Gaps (owner valid=0) mid-frame are allowed without limit; the grant is held.
- Minimum inter-frame spacing: one IDLE cycle. This holds even when a client holds valid continuously or the other client is waiting.
- crypto_ready is sampled only in IDLE for data frames. Deassertion during BURST has no effect.
- Key frame while crypto_ready=0 is admitted. The core's key expansion runs independently of the cipher.
- rst during BURST: returns to IDLE with reset values on the next edge. The partial frame is discarded; the core shares rst.
- No combinational path from req*_valid to data_in_valid. req*_ready depends only on registered state.

Test Plan:
- Reset, then client 0 sends key frame (type 01) words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F with crypto_ready=0 → frame admitted; data_in shows the same 4 words one cycle after each accept; key_owner=0, key_loaded=1.
- Both clients hold a data frame valid, crypto_ready=1 → client 0 is granted first; exactly one IDLE cycle follows; then client 1. A further frame from each gives order 0,1,0,1.
- Client 1 data frame with crypto_ready=0 for 10 cycles, then 1 → req1_ready stays 0 throughout; grant appears one cycle after crypto_ready rises.
- Client 0 drops valid for 5 cycles after word 2 while client 1 is valid → grant stays 2'b01; client 1 is not serviced until client 0's word 4 completes.
- Client 0 sends types 00,01,10,11 within one frame → all 4 words are output with type 00.
- Assert rst after word 2 of a frame → the next cycle shows grant=0, data_in_valid=0, req*_ready=0, and key fields at reset values. A fresh frame then completes normally.

Source files
------------

// File: rtl/aes_stream_arb.sv
// aes_stream_arb: round-robin arbiter packing two client word streams into whole 4-word frames for the AES core
// Ports: clk/rst (sync active-high); reqN_valid/type/data in, reqN_ready out per client;
// crypto_ready gates data frames; data_in_valid/type/data_in registered core feed;
// grant one-hot frame owner; key_owner/key_loaded track the last completed key frame.
module aes_stream_arb #(
  parameter int         FRAME_WORDS = 4,
  parameter logic [1:0] TYPE_KEY    = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [1:0]  req0_type,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [1:0]  req1_type,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  input  logic        crypto_ready,
  output logic        data_in_valid,
  output logic [1:0]  data_in_type,
  output logic [31:0] data_in,
  output logic [1:0]  grant,
  output logic        key_owner,
  output logic        key_loaded
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t      r_state, w_next;
  logic        r_owner, r_rr;
  logic [1:0]  r_cnt, r_type;
  logic        w_el0, w_el1, w_pick, w_valid, w_acc, w_last;
  logic [1:0]  w_in_type;
  logic [31:0] w_in_data;
  always_comb begin
    w_el0     = req0_valid && (req0_type == TYPE_KEY || crypto_ready);
    w_el1     = req1_valid && (req1_type == TYPE_KEY || crypto_ready);
    w_pick    = (w_el0 && w_el1) ? r_rr : w_el1;
    w_valid   = r_owner ? req1_valid : req0_valid;
    w_in_type = r_owner ? req1_type : req0_type;
    w_in_data = r_owner ? req1_data : req0_data;
    w_acc     = r_state == BURST && w_valid;
    w_last    = w_acc && r_cnt == 2'(FRAME_WORDS - 1);
    w_next    = r_state == IDLE ? ((w_el0 || w_el1) ? BURST : IDLE) : (w_last ? IDLE : BURST);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_owner       <= 1'b0;
      r_rr          <= 1'b0;
      r_cnt         <= 2'd0;
      r_type        <= 2'd0;
      data_in_valid <= 1'b0;
      data_in_type  <= 2'd0;
      data_in       <= 32'd0;
      key_owner     <= 1'b0;
      key_loaded    <= 1'b0;
    end else begin
      r_state       <= w_next;
      data_in_valid <= w_acc;
      if (r_state == IDLE && w_next == BURST) r_owner <= w_pick;
      if (w_acc) begin
        data_in      <= w_in_data;
        data_in_type <= r_cnt == 2'd0 ? w_in_type : r_type;
        r_cnt        <= r_cnt + 2'd1;
      end
      // frame type is fixed by its first word
      if (w_acc && r_cnt == 2'd0) r_type <= w_in_type;
      if (w_last) begin
        r_rr <= ~r_owner;
        if (r_type == TYPE_KEY) begin
          key_owner  <= r_owner;
          key_loaded <= 1'b1;
        end
      end
    end
  end
  assign req0_ready = r_state == BURST && !r_owner;
  assign req1_ready = r_state == BURST && r_owner;
  assign grant      = {req1_ready, req0_ready};
endmodule
